regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Write-back queue that owns the write side of the 32x32 MIPS register file. It buffers completed write-back results (register address plus 32-bit data) from the execute/memory stages through a valid/ready handshake. It drains one entry per clock into the register file's synchronous write port (`WriteData`, `WriteRegister`, `RegWrite`). It also provides optional read-side forwarding of values that are still pending, so the two asynchronous read ports never return stale data.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, minimum 2.
- `Clk`  in  1  clock; all state updates on the positive edge.
- `Reset`  in  1  synchronous, active-high reset.
- `InValid`  in  1  producer has a write-back request this cycle.
- `InReady`  out  1  queue accepts the request this cycle.
- `InRegister`  in  5  destination register address.
- `InData`  in  32  destination data.
- `Stall`  in  1  when high, hold the queue head and do not write the register file.
- `WriteData`  out  32  to the register file `WriteData`.
- `WriteRegister`  out  5  to the register file `WriteRegister`.
- `RegWrite`  out  1  to the register file `RegWrite`.
- `ReadRegister1`, `ReadRegister2`  in  5 each  addresses currently presented to the register file read ports.
- `Fwd1Hit`, `Fwd2Hit`  out  1 each  a pending entry matches the corresponding read address.
- `Fwd1Data`, `Fwd2Data`  out  32 each  data of the youngest matching pending entry.
- `Count`  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding a 5-bit address and 32-bit data.
- State is a head pointer, a tail pointer (log2(DEPTH) bits each, wrapping modulo DEPTH) and a count.
- Enqueue handshake:
  - A request is accepted at a rising edge when `InValid && InReady`.
  - `InReady = !Reset && (Count != DEPTH)`.
  - There is no same-cycle pass-through. A full queue deasserts `InReady` even if a dequeue occurs in that cycle.
- Register 0 requests (`InRegister == 0`):
  - The handshake completes normally.
  - The entry is not stored: tail and count are unchanged.
- Dequeue:
  - `RegWrite = !Reset && (Count != 0) && !Stall`.
  - `WriteRegister` and `WriteData` present the head entry. Both are 0 when `Count == 0`.
  - On the edge where `RegWrite` is high, the register file captures the head and the head pointer advances.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
- Ordering: strictly FIFO. Writes to the same register retire in arrival order, so the last write wins.
- Forwarding:
  - Combinational match of `ReadRegisterN` against all occupied entries, including the head being written this cycle.
  - The youngest match (closest to tail) wins.
  - Address 0 never hits. On a miss, `FwdNHit=0` and `FwdNData=0`.
  - The consumer muxes `FwdNData` over the register file read data when `FwdNHit` is set.

## Timing
- Reset (synchronous):
  - Clears head, tail and `Count`. Entry contents are don't-care.
  - While `Reset` is high: `InReady=0`, `RegWrite=0`, `WriteRegister=0`, `WriteData=0`, `Fwd*Hit=0`, `Fwd*Data=0`.
  - Reset asserted mid-operation discards all pending entries. No register file write occurs on that edge.
- Latency: a request accepted at edge N is written to the register file at edge N+1 at the earliest (empty queue, `Stall` low). Each older pending entry adds one cycle, and each stalled cycle adds one cycle.
- Throughput: one enqueue and one dequeue per cycle.
- `Count` updates on the edge following a handshake. It ranges 0..DEPTH and never wraps.
- Forward outputs are purely combinational from current state and read addresses. There is no added cycle.

## Configuration
- `REGFILE_WB_QUEUE_FORWARD_EN`:
  - Defined: forwarding comparators and youngest-match priority logic are compiled in, as described above.
  - Undefined: the logic is removed. `Fwd1Hit`, `Fwd2Hit`, `Fwd1Data` and `Fwd2Data` are tied to 0, and ports are retained. Consumers must stall reads of pending registers externally.

## Test plan
- Reset then single write:
  - Stimulus: Reset 1 cycle, then enqueue (r5, 0xDEADBEEF).
  - Required response: at the next cycle `RegWrite=1`, `WriteRegister=5`, `WriteData=0xDEADBEEF`. After that edge, `Count=0` and register 5 reads 0xDEADBEEF.
- Fill with `Stall=1`:
  - Stimulus: enqueue r1..r4 with data 0x11..0x44.
  - Required response: `Count=4`, `InReady=0`, and a 5th request is not accepted.
  - Then release `Stall`: writes r1..r4 occur in order on 4 consecutive edges, and `InReady` returns to 1 after the first dequeue edge.
- Register 0 drop:
  - Stimulus: enqueue (r0, 0x12345678).
  - Required response: the handshake completes, `Count` stays 0, `RegWrite` never asserts, and r0 reads 0.
- Forwarding priority (`FORWARD_EN` defined):
  - Stimulus: `Stall=1`, enqueue (r7, 0xAAAA0000) then (r7, 0xBBBB0000), `ReadRegister1=7`.
  - Required response: `Fwd1Hit=1`, `Fwd1Data=0xBBBB0000`. With `ReadRegister2=0`, `Fwd2Hit=0`.
- Wrap-around plus simultaneous traffic:
  - Stimulus: stream 10 back-to-back requests (r1..r10, data = address×3) with `Stall` low.
  - Required response: `Count` stays ≤1, and each register holds its value in order across pointer wrap.
- Mid-operation reset:
  - Stimulus: with 3 pending entries, assert `Reset` for 1 cycle.
  - Required response: `Count=0`, no `RegWrite` during or after reset, and the pending registers keep their old values.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back queue that owns the write port of the 32x32
// MIPS register file. Results from execute/memory are buffered in a circular
// FIFO and retired one per clock into the register file's synchronous write
// port. Optional read-side forwarding of still-pending values is compiled in
// when the macro REGFILE_WB_QUEUE_FORWARD_EN is defined; otherwise the
// forwarding outputs are tied to zero.
module regfile_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [4:0]                 InRegister,
   input  logic [31:0]                InData,
   input  logic                       Stall,
   output logic [31:0]                WriteData,
   output logic [4:0]                 WriteRegister,
   output logic                       RegWrite,
   input  logic [4:0]                 ReadRegister1,
   input  logic [4:0]                 ReadRegister2,
   output logic                       Fwd1Hit,
   output logic                       Fwd2Hit,
   output logic [31:0]                Fwd1Data,
   output logic [31:0]                Fwd2Data,
   output logic [$clog2(DEPTH):0]     Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [4:0]    entryReg_q  [DEPTH];
   logic [31:0]   entryData_q [DEPTH];
   logic [AW-1:0] headPtr_q, headPtr_d;
   logic [AW-1:0] tailPtr_q, tailPtr_d;
   logic [CW-1:0] count_q, count_d;

   logic accept;
   logic storeEntry;
   logic dequeue;

   // Handshake and retire decisions. A full queue refuses new work even if
   // the head drains in the same cycle, and register 0 requests complete the
   // handshake but are never stored since r0 is hard-wired to zero.
   always_comb begin
      InReady    = !Reset && (count_q != FULL_COUNT);
      accept     = InValid && InReady;
      storeEntry = accept && (InRegister != 5'd0);
      dequeue    = !Reset && (count_q != '0) && !Stall;
   end

   // Register file write port driven straight from the head entry; forced to
   // zero when empty or in reset so the register file never sees stale data.
   always_comb begin
      RegWrite      = dequeue;
      WriteRegister = 5'd0;
      WriteData     = 32'd0;
      if (!Reset && (count_q != '0)) begin
         WriteRegister = entryReg_q[headPtr_q];
         WriteData     = entryData_q[headPtr_q];
      end
   end

   // Next-state pointers and occupancy; both pointers may advance together.
   always_comb begin
      headPtr_d = headPtr_q;
      tailPtr_d = tailPtr_q;
      count_d   = count_q;
      if (storeEntry) begin
         tailPtr_d = tailPtr_q + AW'(1);
      end
      if (dequeue) begin
         headPtr_d = headPtr_q + AW'(1);
      end
      case ({storeEntry, dequeue})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count state with synchronous reset; reset discards every
   // pending entry without writing any of them back.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         headPtr_q <= '0;
         tailPtr_q <= '0;
         count_q   <= '0;
      end else begin
         headPtr_q <= headPtr_d;
         tailPtr_q <= tailPtr_d;
         count_q   <= count_d;
      end
   end

   // Entry storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge Clk) begin
      if (storeEntry) begin
         entryReg_q[tailPtr_q]  <= InRegister;
         entryData_q[tailPtr_q] <= InData;
      end
   end

   assign Count = count_q;

`ifdef REGFILE_WB_QUEUE_FORWARD_EN
   // Forwarding lookup: walk occupied slots oldest to youngest so the last
   // match found (closest to tail) wins. The head being written this cycle
   // still counts as pending. Address 0 never hits.
   always_comb begin
      logic [AW-1:0] slot;
      slot     = '0;
      Fwd1Hit  = 1'b0;
      Fwd2Hit  = 1'b0;
      Fwd1Data = 32'd0;
      Fwd2Data = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = headPtr_q + AW'(i);
         if (CW'(i) < count_q) begin
            if ((ReadRegister1 != 5'd0) && (entryReg_q[slot] == ReadRegister1)) begin
               Fwd1Hit  = 1'b1;
               Fwd1Data = entryData_q[slot];
            end
            if ((ReadRegister2 != 5'd0) && (entryReg_q[slot] == ReadRegister2)) begin
               Fwd2Hit  = 1'b1;
               Fwd2Data = entryData_q[slot];
            end
         end
      end
      if (Reset) begin
         Fwd1Hit  = 1'b0;
         Fwd2Hit  = 1'b0;
         Fwd1Data = 32'd0;
         Fwd2Data = 32'd0;
      end
   end
`else
   // Forwarding removed: outputs held at zero and the read addresses are
   // intentionally left unused; consumers must interlock on pending registers.
   logic unusedReadAddr;
   assign unusedReadAddr = ^{ReadRegister1, ReadRegister2};
   assign Fwd1Hit  = 1'b0;
   assign Fwd2Hit  = 1'b0;
   assign Fwd1Data = 32'd0;
   assign Fwd2Data = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed bench for regfile_wb_queue with a behavioural
// register file hanging off the write port. Expectations are hand-computed.
module tb_regfile_wb_queue;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InRegister;
   logic [31:0] InData;
   logic        Stall;
   logic [31:0] WriteData;
   logic [4:0]  WriteRegister;
   logic        RegWrite;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic        Fwd1Hit;
   logic        Fwd2Hit;
   logic [31:0] Fwd1Data;
   logic [31:0] Fwd2Data;
   logic [2:0]  Count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rfModel [32] = '{default: 32'd0};

   regfile_wb_queue #(.DEPTH(4)) dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .InRegister(InRegister), .InData(InData), .Stall(Stall),
      .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .Fwd1Hit(Fwd1Hit), .Fwd2Hit(Fwd2Hit), .Fwd1Data(Fwd1Data),
      .Fwd2Data(Fwd2Data), .Count(Count)
   );

   // Free-running clock, 10 time-unit period.
   always #5 Clk = ~Clk;

   // Behavioural register file capturing the write port.
   always @(posedge Clk) begin
      if (RegWrite === 1'b1) rfModel[WriteRegister] <= WriteData;
   end

   // Advance one clock and settle just after the edge.
   task automatic applyStimulus();
      @(posedge Clk);
      #1;
   endtask

   // One counted comparison.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; InRegister = 5'd0; InData = 32'd0;
      Stall = 1'b0; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;

      // Reset behaviour
      applyStimulus();
      ReadRegister1 = 5'd5;
      #1;
      checkOutput("rst_inready", 32'(InReady), 32'd0);
      checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
      checkOutput("rst_wreg", 32'(WriteRegister), 32'd0);
      checkOutput("rst_wdata", WriteData, 32'd0);
      checkOutput("rst_fwd1hit", 32'(Fwd1Hit), 32'd0);
      Reset = 1'b0;
      #1;
      checkOutput("post_rst_count", 32'(Count), 32'd0);
      checkOutput("post_rst_inready", 32'(InReady), 32'd1);

      // Single write to r5
      InValid = 1'b1; InRegister = 5'd5; InData = 32'hDEADBEEF;
      applyStimulus();
      InValid = 1'b0;
      #1;
      checkOutput("single_regwrite", 32'(RegWrite), 32'd1);
      checkOutput("single_wreg", 32'(WriteRegister), 32'd5);
      checkOutput("single_wdata", WriteData, 32'hDEADBEEF);
      applyStimulus();
      checkOutput("single_count", 32'(Count), 32'd0);
      checkOutput("single_rf5", rfModel[5], 32'hDEADBEEF);
      checkOutput("single_idle", 32'(RegWrite), 32'd0);

      // Fill while stalled
      Stall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         InValid = 1'b1; InRegister = 5'(i); InData = 32'(i * 'h11);
         #1;
         checkOutput($sformatf("fill_inready_%0d", i), 32'(InReady), 32'd1);
         applyStimulus();
      end
      InRegister = 5'd9; InData = 32'h99;
      #1;
      checkOutput("full_count", 32'(Count), 32'd4);
      checkOutput("full_inready", 32'(InReady), 32'd0);
      checkOutput("full_stall_nowrite", 32'(RegWrite), 32'd0);
      applyStimulus();
      InValid = 1'b0;
      ReadRegister1 = 5'd3;
      #1;
      checkOutput("full_fifth_rejected", 32'(Count), 32'd4);
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
      checkOutput("full_fwd1hit", 32'(Fwd1Hit), 32'd1);
      checkOutput("full_fwd1data", Fwd1Data, 32'h33);
`else
      checkOutput("full_fwd1hit_off", 32'(Fwd1Hit), 32'd0);
      checkOutput("full_fwd1data_off", Fwd1Data, 32'd0);
`endif
      Stall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checkOutput($sformatf("drain_regwrite_%0d", i), 32'(RegWrite), 32'd1);
         checkOutput($sformatf("drain_wreg_%0d", i), 32'(WriteRegister), 32'(i));
         checkOutput($sformatf("drain_wdata_%0d", i), WriteData, 32'(i * 'h11));
         applyStimulus();
         if (i == 1) checkOutput("drain_inready_back", 32'(InReady), 32'd1);
      end
      checkOutput("drain_count", 32'(Count), 32'd0);
      checkOutput("drain_rf4", rfModel[4], 32'h44);
      checkOutput("drain_rf9_untouched", rfModel[9], 32'd0);

      // Register 0 drop
      InValid = 1'b1; InRegister = 5'd0; InData = 32'h12345678;
      #1;
      checkOutput("r0_inready", 32'(InReady), 32'd1);
      applyStimulus();
      InValid = 1'b0;
      #1;
      checkOutput("r0_count", 32'(Count), 32'd0);
      checkOutput("r0_regwrite", 32'(RegWrite), 32'd0);
      applyStimulus();
      checkOutput("r0_rf0", rfModel[0], 32'd0);

      // Forwarding priority
      Stall = 1'b1;
      InValid = 1'b1; InRegister = 5'd7; InData = 32'hAAAA0000;
      applyStimulus();
      InData = 32'hBBBB0000;
      applyStimulus();
      InValid = 1'b0;
      ReadRegister1 = 5'd7; ReadRegister2 = 5'd0;
      #1;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
      checkOutput("fwd_youngest_hit", 32'(Fwd1Hit), 32'd1);
      checkOutput("fwd_youngest_data", Fwd1Data, 32'hBBBB0000);
`else
      checkOutput("fwd_off_hit", 32'(Fwd1Hit), 32'd0);
      checkOutput("fwd_off_data", Fwd1Data, 32'd0);
`endif
      checkOutput("fwd_r0_hit", 32'(Fwd2Hit), 32'd0);
      checkOutput("fwd_r0_data", Fwd2Data, 32'd0);
      checkOutput("fwd_count", 32'(Count), 32'd2);
      Stall = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("fwd_rf7_last_wins", rfModel[7], 32'hBBBB0000);
      checkOutput("fwd_drained", 32'(Count), 32'd0);

      // Streaming with wrap-around
      ReadRegister1 = 5'd0;
      for (int i = 1; i <= 10; i++) begin
         InValid = 1'b1; InRegister = 5'(i); InData = 32'(i * 3);
         #1;
         checkOutput($sformatf("stream_count_le1_%0d", i), 32'(Count <= 3'd1), 32'd1);
         applyStimulus();
      end
      InValid = 1'b0;
      applyStimulus();
      checkOutput("stream_count_end", 32'(Count), 32'd0);
      for (int i = 1; i <= 10; i++) begin
         checkOutput($sformatf("stream_rf%0d", i), rfModel[i], 32'(i * 3));
      end

      // Mid-operation reset discards pending entries
      Stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         InValid = 1'b1; InRegister = 5'(i); InData = 32'(i * 'h100);
         applyStimulus();
      end
      InValid = 1'b0;
      checkOutput("midrst_pending", 32'(Count), 32'd3);
      Reset = 1'b1; Stall = 1'b0;
      #1;
      checkOutput("midrst_nowrite_during", 32'(RegWrite), 32'd0);
      checkOutput("midrst_wreg_zero", 32'(WriteRegister), 32'd0);
      applyStimulus();
      Reset = 1'b0;
      #1;
      checkOutput("midrst_count", 32'(Count), 32'd0);
      checkOutput("midrst_nowrite_after", 32'(RegWrite), 32'd0);
      applyStimulus();
      checkOutput("midrst_rf1_kept", rfModel[1], 32'd3);
      checkOutput("midrst_rf2_kept", rfModel[2], 32'd6);
      checkOutput("midrst_rf3_kept", rfModel[3], 32'd9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
